// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a loadable pattern, selectable overlap mode and a
// saturating match counter. One bit is sampled per enabled clock.
module seq_detect_param #(
  parameter int unsigned           PAT_W   = 3,
  parameter int unsigned           CNT_W   = 8,
  parameter logic [PAT_W-1:0]      RST_PAT = {PAT_W{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             din_i,
  input  logic             pat_load_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             ovl_i,
  output logic             dout_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  // Only the newest PAT_W-1 bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] window;
  logic [FillW-1:0] fill_inc;
  logic             hit;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pat_q  <= RST_PAT;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic: FILLING while fill_q < PAT_W, ARMED once it reaches PAT_W
  always_comb begin
    window   = {hist_q, din_i};
    fill_inc = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
    hit      = (fill_inc == FillFull) && (window == pat_q);

    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    dout_d = 1'b0;
    cnt_d  = cnt_q;

    if (pat_load_i) begin
      pat_d  = pattern_i;
      ovl_d  = ovl_i;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en_i) begin
      hist_d = window[PAT_W-2:0];
      fill_d = fill_inc;
      dout_d = hit;
      if (hit) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        // Non-overlap mode discards the matched window entirely.
        if (!ovl_q) fill_d = '0;
      end
    end
  end

  // Outputs
  always_comb begin
    dout_o      = dout_q;
    match_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a default instance and a 2-bit-counter instance
// share one stimulus stream and are checked against a window model of the detector.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       pat_load;
  logic [2:0] pattern;
  logic       ovl;
  logic       dout8, dout2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  seq_detect_param #(.PAT_W(3), .CNT_W(8), .RST_PAT(3'b111)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .din_i      (din),
    .pat_load_i (pattern == pattern ? pat_load : 1'b0),
    .pattern_i  (pattern),
    .ovl_i      (ovl),
    .dout_o     (dout8),
    .match_cnt_o(cnt8)
  );

  seq_detect_param #(.PAT_W(3), .CNT_W(2), .RST_PAT(3'b111)) dut_sat (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .din_i      (din),
    .pat_load_i (pat_load),
    .pattern_i  (pattern),
    .ovl_i      (ovl),
    .dout_o     (dout2),
    .match_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     dout;
    int       cnt8;
    int       cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  // Reference model state: the pattern, mode, the last three bits and how many are valid.
  logic [2:0] m_pat;
  logic       m_ovl;
  logic [2:0] m_win;
  int         m_valid;
  int         m_cnt8;
  int         m_cnt2;
  logic       m_dout;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [2:0] p, input logic o);
    m_pat   = p;
    m_ovl   = o;
    m_win   = '0;
    m_valid = 0;
    m_cnt8  = 0;
    m_cnt2  = 0;
    m_dout  = 1'b0;
  endtask

  // Drive one edge's inputs, advance the model, queue the expectation, then compare.
  task automatic step(input logic r, input logic ld, input logic e, input logic d,
                      input logic [2:0] p, input logic o, input string tag);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst_n = r; pat_load = ld; en = e; din = d; pattern = p; ovl = o;
    if (!r) begin
      model_clear(3'b111, 1'b1);
    end else if (ld) begin
      model_clear(p, o);
    end else if (e) begin
      m_win   = {m_win[1:0], d};
      m_valid = m_valid + 1;
      m_dout  = (m_valid >= 3) && (m_win == m_pat);
      if (m_dout) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!m_ovl) m_valid = 0;
      end
    end else begin
      m_dout = 1'b0;
    end
    x.dout = m_dout; x.cnt8 = m_cnt8; x.cnt2 = m_cnt2;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      got = exp_q.pop_front();
      check({tag, "_dout"}, int'(dout8), int'(got.dout));
      check({tag, "_dout_sat"}, int'(dout2), int'(got.dout));
      check({tag, "_cnt"}, int'(cnt8), got.cnt8);
      check({tag, "_cnt_sat"}, int'(cnt2), got.cnt2);
    end
  endtask

  task automatic bit_in(input logic d, input string tag);
    step(1'b1, 1'b0, 1'b1, d, 3'b000, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, tag);
  endtask

  task automatic do_load(input logic [2:0] p, input logic o, input string tag);
    step(1'b1, 1'b1, 1'b1, 1'b1, p, o, tag);
  endtask

  initial begin
    logic [4:0] t3_bits;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; pat_load = 1'b0; en = 1'b0; din = 1'b0; pattern = '0; ovl = 1'b0;
    model_clear(3'b111, 1'b1);

    // Reset state
    do_reset("rst");
    do_reset("rst");

    // T1: default pattern, five ones in overlap mode
    for (int i = 0; i < 5; i++) bit_in(1'b1, "t1");
    check("t1_total", int'(cnt8), 3);

    // T2: non-overlap 111 over six ones
    do_load(3'b111, 1'b0, "t2_load");
    check("t2_load_dout", int'(dout8), 0);
    for (int i = 0; i < 6; i++) begin
      bit_in(1'b1, "t2");
      check("t2_pulse", int'(dout8), (i == 2 || i == 5) ? 1 : 0);
    end
    check("t2_total", int'(cnt8), 2);

    // T3: 101 in both modes
    t3_bits = 5'b10101;
    do_load(3'b101, 1'b1, "t3o_load");
    for (int i = 4; i >= 0; i--) bit_in(t3_bits[i], "t3o");
    check("t3o_total", int'(cnt8), 2);
    do_load(3'b101, 1'b0, "t3n_load");
    for (int i = 4; i >= 0; i--) bit_in(t3_bits[i], "t3n");
    check("t3n_total", int'(cnt8), 1);

    // T4: enable gap is transparent
    do_reset("t4_rst");
    bit_in(1'b1, "t4");
    bit_in(1'b1, "t4");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "t4_gap");
      check("t4_gap_dout", int'(dout8), 0);
    end
    bit_in(1'b1, "t4");
    check("t4_hit", int'(dout8), 1);

    // T5: reset mid-stream discards history
    bit_in(1'b1, "t5");
    bit_in(1'b1, "t5");
    do_reset("t5_rst");
    check("t5_rst_dout", int'(dout8), 0);
    check("t5_rst_cnt", int'(cnt8), 0);
    bit_in(1'b1, "t5");
    bit_in(1'b1, "t5");
    check("t5_nohit", int'(dout8), 0);
    bit_in(1'b1, "t5");
    check("t5_hit", int'(dout8), 1);

    // T6: counter saturation on the 2-bit instance
    do_reset("t6_rst");
    for (int i = 0; i < 8; i++) begin
      bit_in(1'b1, "t6");
      if (i >= 2) begin
        check("t6_cnt_sat", int'(cnt2), (i - 1 > 3) ? 3 : i - 1);
        check("t6_dout", int'(dout2), 1);
      end
    end

    // Random stream with occasional loads, gaps and resets
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset("rnd_rst");
      else if (r < 6) do_load(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd_load");
      else step(1'b1, 1'b0, (r >= 20), 1'($urandom_range(0, 1)), 3'b000, 1'b0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
